// File: rtl/config_port_arbiter_pkg.sv
// Shared types and constants for the configuration write-port arbiter.
// State encoding, source identifiers and the default bitstream sync word.
package config_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } arb_state_t;

    localparam logic SRC_UART = 1'b0;
    localparam logic SRC_PAR  = 1'b1;

    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

    // True when a strobed word matches the sync pattern
    function automatic logic is_sync(input logic strobe, input logic [31:0] word,
                                     input logic [31:0] sync);
        return strobe && (word == sync);
    endfunction

endpackage

// File: rtl/config_idle_timer.sv
// Idle counter for the port owner; tc is high for the one cycle the count sits at all-ones.
// The count wraps to zero after terminal count so tc is a single-cycle pulse.
module config_idle_timer
    import config_port_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic CLK,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WIDTH-1:0] cnt_r;

    assign tc = &cnt_r;

    // Idle cycle counter: clear wins, terminal count wraps, otherwise count when enabled
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (tc) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/config_port_arbiter.sv
// Shares the config FSM write port between the UART loader and the parallel CPU port.
// A sync word claims the port; header/data framing is tracked to detect the desync end.
module config_port_arbiter
    import config_port_arbiter_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
    parameter int          DESYNC_FLAG   = 20,
    parameter int          NUM_ROWS      = 16,
    parameter int          TIMEOUT_WIDTH = 16
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic [31:0] uart_data,
    input  logic        uart_strobe,
    input  logic [31:0] par_data,
    input  logic        par_strobe,
    output logic [31:0] WriteData,
    output logic        WriteStrobe,
    output logic        FSM_Reset,
    output logic        uart_grant,
    output logic        par_grant,
    output logic        conflict,
    output logic        timeout_err
);

    localparam int FRAME_W = $clog2(NUM_ROWS + 1);

    arb_state_t         state_r;
    logic               owner_r;
    logic [FRAME_W-1:0] frame_cnt_r;
    logic [31:0]        write_data_r;
    logic               write_strobe_r;
    logic               fsm_reset_r;
    logic               uart_grant_r;
    logic               par_grant_r;
    logic               conflict_r;
    logic               timeout_err_r;

    logic [31:0] own_data_s;
    logic        own_strobe_s;
    logic        other_strobe_s;
    logic        uart_sync_s;
    logic        par_sync_s;
    logic        timer_clr_s;
    logic        timeout_s;

    assign uart_sync_s = is_sync(uart_strobe, uart_data, SYNC_WORD);
    assign par_sync_s  = is_sync(par_strobe, par_data, SYNC_WORD);

    // Steer the current owner's word and strobe, and flag the other source's strobe
    always_comb begin
        own_data_s     = 32'd0;
        own_strobe_s   = 1'b0;
        other_strobe_s = 1'b0;
        if (state_r == IDLE) begin
            own_data_s     = 32'd0;
            own_strobe_s   = 1'b0;
            other_strobe_s = 1'b0;
        end else if (owner_r == SRC_UART) begin
            own_data_s     = uart_data;
            own_strobe_s   = uart_strobe;
            other_strobe_s = par_strobe;
        end else begin
            own_data_s     = par_data;
            own_strobe_s   = par_strobe;
            other_strobe_s = uart_strobe;
        end
    end

    assign timer_clr_s = (state_r == IDLE) || own_strobe_s;

    config_idle_timer #(
        .WIDTH (TIMEOUT_WIDTH)
    ) u_idle_timer (
        .CLK    (CLK),
        .resetn (resetn),
        .clr    (timer_clr_s),
        .en     (!timer_clr_s),
        .tc     (timeout_s)
    );

    // Ownership FSM with registered forwarding, grant, conflict and timeout outputs
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_r        <= IDLE;
            owner_r        <= SRC_UART;
            frame_cnt_r    <= {FRAME_W{1'b0}};
            write_data_r   <= 32'd0;
            write_strobe_r <= 1'b0;
            fsm_reset_r    <= 1'b0;
            uart_grant_r   <= 1'b0;
            par_grant_r    <= 1'b0;
            conflict_r     <= 1'b0;
            timeout_err_r  <= 1'b0;
        end else begin
            write_strobe_r <= 1'b0;
            fsm_reset_r    <= 1'b0;
            conflict_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (uart_sync_s) begin
                        owner_r        <= SRC_UART;
                        uart_grant_r   <= 1'b1;
                        timeout_err_r  <= 1'b0;
                        write_data_r   <= uart_data;
                        write_strobe_r <= 1'b1;
                        conflict_r     <= par_sync_s;
                        state_r        <= HEADER;
                    end else if (par_sync_s) begin
                        owner_r        <= SRC_PAR;
                        par_grant_r    <= 1'b1;
                        timeout_err_r  <= 1'b0;
                        write_data_r   <= par_data;
                        write_strobe_r <= 1'b1;
                        state_r        <= HEADER;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                HEADER, DATA: begin
                    conflict_r <= other_strobe_s;
                    // Timeout outranks a late owner word, which is dropped
                    if (timeout_s) begin
                        uart_grant_r  <= 1'b0;
                        par_grant_r   <= 1'b0;
                        timeout_err_r <= 1'b1;
                        fsm_reset_r   <= 1'b1;
                        state_r       <= IDLE;
                    end else if (own_strobe_s) begin
                        write_data_r   <= own_data_s;
                        write_strobe_r <= 1'b1;
                        if (state_r == HEADER) begin
                            if (own_data_s[DESYNC_FLAG]) begin
                                uart_grant_r <= 1'b0;
                                par_grant_r  <= 1'b0;
                                state_r      <= IDLE;
                            end else begin
                                frame_cnt_r <= FRAME_W'(NUM_ROWS);
                                state_r     <= DATA;
                            end
                        end else begin
                            frame_cnt_r <= frame_cnt_r - {{(FRAME_W-1){1'b0}}, 1'b1};
                            if (frame_cnt_r == {{(FRAME_W-1){1'b0}}, 1'b1}) begin
                                state_r <= HEADER;
                            end else begin
                                state_r <= DATA;
                            end
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    uart_grant_r <= 1'b0;
                    par_grant_r  <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign WriteData   = write_data_r;
    assign WriteStrobe = write_strobe_r;
    assign FSM_Reset   = fsm_reset_r;
    assign uart_grant  = uart_grant_r;
    assign par_grant   = par_grant_r;
    assign conflict    = conflict_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: doc/config_port_arbiter.md
Name: config_port_arbiter

Overview:
Shares the single fabric configuration write port (WriteData/WriteStrobe/FSM_Reset into the config FSM) between two bitstream sources: UART loader and parallel CPU port. Ownership is granted on a sync word and held until the bitstream desyncs or stalls. The block tracks the config FSM's header/data framing so it knows when a bitstream ends. It sits between the two loaders and the config FSM.

Parameters:
SYNC_WORD, 32'hFAB0_FAB1, word that opens a bitstream and claims ownership
DESYNC_FLAG, 20, bit index in a header word that ends the bitstream
NUM_ROWS, 16, data words per frame following each header
TIMEOUT_WIDTH, 16, idle-timeout counter width; timeout at 2**TIMEOUT_WIDTH-1 idle cycles

Ports:
CLK  in  1  clock
resetn  in  1  reset
uart_data  in  32  UART loader word
uart_strobe  in  1  UART word valid, 1 cycle per word
par_data  in  32  parallel port word
par_strobe  in  1  parallel word valid, 1 cycle per word
WriteData  out  32  word to config FSM, registered
WriteStrobe  out  1  word valid to config FSM, registered
FSM_Reset  out  1  1-cycle pulse; config FSM resets on its rising edge
uart_grant  out  1  UART owns the port
par_grant  out  1  parallel port owns the port
conflict  out  1  1-cycle pulse: a non-owner strobe was dropped
timeout_err  out  1  sticky; set on timeout release, cleared on next grant

Interface: one clock; reset is asynchronous and active-low (CLK, resetn).

Behaviour:
- Reset values: WriteData=0, WriteStrobe=0, FSM_Reset=0, both grants=0, conflict=0, timeout_err=0, state=IDLE, counters=0.
- Latency: an accepted word appears on WriteData/WriteStrobe exactly 1 cycle after its input strobe. Dropped words never appear.
- State IDLE:
  - A strobe carrying SYNC_WORD grants the source and is forwarded; go to HEADER.
  - Strobes carrying any other word are dropped silently, with no conflict pulse.
  - If both sources strobe SYNC_WORD in the same cycle, UART wins and parallel gets a conflict pulse.
- State HEADER (owner strobe only):
  - If word[DESYNC_FLAG]=1: forward it, clear the grant, go to IDLE.
  - Otherwise: forward it, load frame_cnt=NUM_ROWS, go to DATA.
- State DATA (owner strobe only): forward the word and decrement frame_cnt. When frame_cnt==1, go to HEADER.
- Non-owner strobe in HEADER/DATA: drop it and pulse conflict the next cycle.
- Owner idle timeout:
  - The idle counter counts cycles without an owner strobe while not IDLE, and clears on every owner strobe.
  - At all-ones: clear the grant, go to IDLE, set timeout_err, and pulse FSM_Reset for 1 cycle. No WriteStrobe is issued that cycle.
  - An owner strobe arriving in the timeout cycle is dropped.
- FSM_Reset is asserted only on timeout. It is never high in the same cycle as WriteStrobe.
- Grants are mutually exclusive at all times. A grant changes only in IDLE (set) or at release (clear).
- A re-sync word seen in HEADER/DATA is treated as ordinary data; there is no re-grant.
- Asynchronous reset mid-bitstream returns everything to reset values immediately. The config FSM is reset by the same resetn.

Decomposition:
- Shared package holds:
  - state encoding IDLE=2'd0, HEADER=2'd1, DATA=2'd2;
  - source IDs SRC_UART=1'b0, SRC_PAR=1'b1;
  - the SYNC_WORD constant.
- One natural sub-module: config_idle_timer, a TIMEOUT_WIDTH counter with clear/enable and a terminal-count pulse.
- The rest stays in one file (est. 180-250 lines).

Test Plan:
- UART sends FAB0FAB1, header 0x00000001, 16 data words, header 0x00100000 -> 19 words forwarded, each 1 cycle late; uart_grant high from cycle+1 after sync until after the desync header; ends in IDLE.
- Both sources strobe FAB0FAB1 in the same cycle -> uart_grant=1, par_grant=0, conflict pulses once, only the UART word is forwarded.
- Parallel owns and is mid-DATA (frame_cnt=8); UART strobes 3 words -> 3 conflict pulses, none forwarded, parallel frame completes normally.
- Parallel sends sync + header, then goes silent 2**TIMEOUT_WIDTH-1 cycles (TIMEOUT_WIDTH=4 in bench) -> FSM_Reset 1-cycle pulse, par_grant=0, timeout_err=1. A later UART sync is granted and clears timeout_err.
- In IDLE, words 0x12345678 and 0xFAB0FAB0 from either source -> no WriteStrobe, no conflict, no grant.
- resetn deasserted mid-DATA -> all outputs 0 asynchronously. After release, a fresh sync is granted normally.
